// File: rtl/fma_operand_sequencer.sv
// Operand sequencer in front of the serial-load FP fma unit.
// Replays {a,b,c} onto float_in, waits for the result, returns it.
module fma_operand_sequencer #(
  parameter int FP_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_WIDTH-1:0] in_a,
  input  logic [FP_WIDTH-1:0] in_b,
  input  logic [FP_WIDTH-1:0] in_c,
  output logic                fma_start,
  output logic [FP_WIDTH-1:0] fma_float_in,
  input  logic [FP_WIDTH-1:0] fma_float_out,
  input  logic                fma_error,
  input  logic                fma_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_WIDTH-1:0] out_result,
  output logic                out_error,
  output logic                out_timeout,
  output logic                busy
);

  localparam int CW =
    $clog2(TIMEOUT_CYCLES + RECOVER_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_SEND_C,
    S_WAIT,
    S_RECOVER,
    S_RESULT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [FP_WIDTH-1:0] r_b;
  logic [FP_WIDTH-1:0] r_c;
  logic                r_err;
  logic                r_fma_start;
  logic [FP_WIDTH-1:0] r_float_in;
  logic                r_out_valid;
  logic [FP_WIDTH-1:0] r_out_result;
  logic                r_out_error;
  logic                r_out_timeout;

  logic w_in_send;
  logic w_err_now;
  logic w_wait_hit;
  logic w_rec_done;
  logic w_accept;
  logic w_done;

  assign w_in_send  = (r_state == S_SEND_A) ||
                      (r_state == S_SEND_B) ||
                      (r_state == S_SEND_C);
  assign w_err_now  = r_err | (w_in_send & fma_error);
  assign w_wait_hit = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_rec_done = (r_cnt == CW'(RECOVER_CYCLES - 1));
  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_done     = (r_state == S_RESULT) &&
                      r_out_valid && out_ready;

  assign in_ready     = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign fma_start    = r_fma_start;
  assign fma_float_in = r_float_in;
  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_error    = r_out_error;
  assign out_timeout  = r_out_timeout;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (in_valid) w_next = S_SEND_A;
      S_SEND_A:  w_next = S_SEND_B;
      S_SEND_B:  w_next = S_SEND_C;
      S_SEND_C:  w_next = w_err_now ? S_RECOVER : S_WAIT;
      S_WAIT:    if (fma_ready || w_wait_hit) w_next = S_RESULT;
      S_RECOVER: if (w_rec_done) w_next = S_RESULT;
      S_RESULT:  if (w_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Operand hold and sticky error latch across the SEND cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_b   <= '0;
      r_c   <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_b   <= in_b;
      r_c   <= in_c;
      r_err <= 1'b0;
    end else if (w_in_send) begin
      r_err <= w_err_now;
    end
  end

  // fma bus drive, registered from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fma_start <= 1'b0;
      r_float_in  <= '0;
    end else begin
      r_fma_start <= (w_next == S_SEND_A);
      unique case (w_next)
        S_SEND_A: r_float_in <= in_a;
        S_SEND_B: r_float_in <= r_b;
        S_SEND_C: r_float_in <= r_c;
        default:  r_float_in <= '0;
      endcase
    end
  end

  // Dwell counter for WAIT and RECOVER, cleared on entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((r_state == w_next) &&
                 ((r_state == S_WAIT) ||
                  (r_state == S_RECOVER))) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Result capture and output handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_error   <= 1'b0;
      r_out_timeout <= 1'b0;
    end else begin
      if (r_state == S_WAIT) begin
        if (fma_ready) begin
          r_out_result <= fma_float_out;
        end else if (w_wait_hit) begin
          r_out_result  <= '1;
          r_out_timeout <= 1'b1;
        end
      end
      if ((r_state == S_RECOVER) && w_rec_done) begin
        r_out_result <= '1;
        r_out_error  <= 1'b1;
      end
      if ((w_next == S_RESULT) && (r_state != S_RESULT)) begin
        r_out_valid <= 1'b1;
      end
      if (w_done) begin
        r_out_valid   <= 1'b0;
        r_out_error   <= 1'b0;
        r_out_timeout <= 1'b0;
      end
    end
  end

endmodule
